truth_table_sequencer: RTL and testbench

- Self-checking stimulus controller for small combinational gate blocks, e.g. the 3-input NAND implementation.
- Steps the DUT inputs through all 2**N_IN vectors in ascending order and holds each vector for a settle window.
- Samples the DUT output once per vector and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector and an overall pass flag.
- Replaces hand-written #delay vector lists with a clocked, reusable sequencer.

---
 rtl/truth_table_sequencer.sv | 147 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: clocked stimulus/checker for small combinational
// blocks. Walks every input vector in ascending order and holds each one
// for a settle window. It samples the DUT output once per vector and
// accumulates the mismatch count, the first failing vector and a pass flag.
module truth_table_sequencer #(
    parameter int                    N_IN       = 3,
    parameter int                    SETTLE_CYC = 2,
    parameter logic [(2**N_IN)-1:0]  EXPECT     = 8'b0111_1111
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_dut_y,
    output logic [N_IN-1:0] o_vec,
    output logic            o_vec_valid,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count,
    output logic [N_IN-1:0] o_first_fail,
    output logic            o_fail_seen
);

    // Counter only ever holds SETTLE_CYC-1 down to 0.
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int EW = N_IN + 1;

    localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;
    localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
    localparam logic [EW-1:0]   ERR_ONE    = EW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N_IN-1:0] r_vec;
    logic            r_vec_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [EW-1:0]   r_err;
    logic [N_IN-1:0] r_first_fail;
    logic            r_fail_seen;

    logic            w_mis;
    logic [EW-1:0]   w_err_nxt;

    // Mismatch of the current vector and the error count including it;
    // the latter feeds pass on the final sample so it sees the last result.
    assign w_mis     = i_dut_y ^ EXPECT[r_vec];
    assign w_err_nxt = r_err + (w_mis ? ERR_ONE : '0);

    // Sweep FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_vec        <= '0;
            r_vec_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort is irrelevant here; start always wins in IDLE
                    if (i_start) begin
                        r_state      <= S_SETTLE;
                        r_vec        <= '0;
                        r_cnt        <= CNT_RELOAD;
                        r_busy       <= 1'b1;
                        r_vec_valid  <= 1'b1;
                        r_err        <= '0;
                        r_first_fail <= '0;
                        r_fail_seen  <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (i_abort) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_vec_valid <= 1'b0;
                        r_pass      <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    // An abort here drops this cycle's sample entirely.
                    if (i_abort) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_vec_valid <= 1'b0;
                        r_pass      <= 1'b0;
                    end else begin
                        r_err <= w_err_nxt;
                        if (w_mis && !r_fail_seen) begin
                            r_first_fail <= r_vec;
                            r_fail_seen  <= 1'b1;
                        end
                        if (r_vec == VEC_LAST) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_vec_valid <= 1'b0;
                            r_pass      <= (w_err_nxt == '0);
                        end else begin
                            r_vec   <= r_vec + VEC_ONE;
                            r_cnt   <= CNT_RELOAD;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    // start is not queued: anything seen here is dropped
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_vec        = r_vec;
    assign o_vec_valid  = r_vec_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_first_fail = r_first_fail;
    assign o_fail_seen  = r_fail_seen;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: NAND3, stuck-at-1 and AND3
// DUT models, abort, ignored start, async reset and a SETTLE_CYC=1 instance.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       start1 = 1'b0;
    int         mode = 0;       // 0 NAND3, 1 stuck-at-1, 2 AND3

    logic [2:0] vec, vec1;
    logic       vv, busy, done, pass, fs;
    logic       vv1, busy1, done1, pass1, fs1;
    logic [3:0] err, err1;
    logic [2:0] ff, ff1;
    logic       y, y1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y  = (mode == 0) ? ~&vec : (mode == 1) ? 1'b1 : &vec;
    assign y1 = ~&vec1;

    truth_table_sequencer u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dut_y(y), .o_vec(vec), .o_vec_valid(vv), .o_busy(busy),
        .o_done(done), .o_pass(pass), .o_err_count(err),
        .o_first_fail(ff), .o_fail_seen(fs)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYC(1), .EXPECT(8'b0111_1111)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(1'b0),
        .i_dut_y(y1), .o_vec(vec1), .o_vec_valid(vv1), .o_busy(busy1),
        .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_first_fail(ff1), .o_fail_seen(fs1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep (edge 0 samples start), run 40 edges, record done pulses.
    // pester holds start high over edges 2..25, covering the DONE cycle.
    task automatic sweep(input bit pester, input bit chk_vec,
                         output int done_edge, output int n_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_edge = -1;
        n_done = 0;
        chk("start_vec0", 32'(vec), 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_err_clr", 32'(err), 0);
        for (int k = 1; k <= 40; k++) begin
            start = pester && (k >= 2) && (k <= 25);
            tick();
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = k;
            end
            if (chk_vec && k < 24) chk($sformatf("vec_e%0d", k), 32'(vec), 32'(k / 3));
        end
        start = 1'b0;
    endtask

    int de, nd;

    initial begin
        // reset state
        #3;
        chk("rst_vec", 32'(vec), 0);
        chk("rst_flags", 32'({vv, busy, done, pass, fs}), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ff", 32'(ff), 0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // 1. correct NAND3: per-edge vectors, done after edge 24, pass
        mode = 0;
        sweep(1'b0, 1'b1, de, nd);
        chk("t1_done_edge", 32'(de), 24);
        chk("t1_n_done", 32'(nd), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_fs", 32'(fs), 0);
        chk("t1_vec_hold", 32'(vec), 7);
        chk("t1_vv_off", 32'(vv), 0);

        // 2. stuck-at-1: only vector 7 fails
        mode = 1;
        sweep(1'b0, 1'b0, de, nd);
        chk("t2_err", 32'(err), 1);
        chk("t2_ff", 32'(ff), 7);
        chk("t2_fs", 32'(fs), 1);
        chk("t2_pass", 32'(pass), 0);

        // 3. AND3: every vector fails
        mode = 2;
        sweep(1'b0, 1'b0, de, nd);
        chk("t3_err", 32'(err), 8);
        chk("t3_ff", 32'(ff), 0);
        chk("t3_pass", 32'(pass), 0);
        chk("t3_done_edge", 32'(de), 24);

        // 4. abort at vec 3 with AND3 model: partial results kept
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && vec != 3'd3; i++) tick();
        chk("t4_reach3", 32'(vec), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_vv", 32'(vv), 0);
        chk("t4_pass", 32'(pass), 0);
        chk("t4_err_partial", 32'(err), 3);
        chk("t4_fs_partial", 32'(fs), 1);
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) nd++;
        end
        chk("t4_no_done", 32'(nd), 0);
        mode = 0;
        sweep(1'b0, 1'b0, de, nd);
        chk("t4_rerun_pass", 32'(pass), 1);
        chk("t4_rerun_err", 32'(err), 0);

        // 5. start hammered during sweep and DONE cycle: ignored
        sweep(1'b1, 1'b1, de, nd);
        chk("t5_done_edge", 32'(de), 24);
        chk("t5_n_done", 32'(nd), 1);
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_pass", 32'(pass), 1);

        // 6. async reset between edges at vec 5, then SETTLE_CYC=1 instance
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && vec != 3'd5; i++) tick();
        chk("t6_reach5", 32'(vec), 5);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_vec", 32'(vec), 0);
        chk("t6_rst_flags", 32'({vv, busy, done, pass, fs}), 0);
        chk("t6_rst_err", 32'(err), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle_vv", 32'(vv), 0);
        chk("t6_idle_busy", 32'(busy), 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        de = -1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (done1 && de < 0) de = k;
        end
        chk("t6_sc1_done_edge", 32'(de), 16);
        chk("t6_sc1_pass", 32'(pass1), 1);
        chk("t6_sc1_err", 32'(err1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
